// File: rtl/isqrt_pkg.sv
// isqrt_pkg -- shared definitions for the iterative integer square root.
//   isqrt_state_e     : FSM state encoding (IDLE / CALC / DONE)
//   isqrt_iter_count  : number of CALC step cycles for a given IN_W / BITS_PER_CYC
//   isqrt_cfg_ok      : parameter legality (IN_W even and >= 4, BITS_PER_CYC divides IN_W/2)
package isqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } isqrt_state_e;

   function automatic int unsigned isqrt_iter_count(input int unsigned in_w,
                                                    input int unsigned bpc);
      return (in_w / 2) / bpc;
   endfunction

   function automatic bit isqrt_cfg_ok(input int unsigned in_w,
                                       input int unsigned bpc);
      return (in_w >= 4) && (in_w % 2 == 0) && (bpc >= 1) && ((in_w / 2) % bpc == 0);
   endfunction

endpackage

// File: rtl/isqrt_step.sv
// isqrt_step -- one combinational non-restoring square-root step.
//   a_top2_i : next two radicand bits (MSB first)
//   r_i/r_o  : partial remainder, two's complement, OUT_W+2 bits
//   q_i/q_o  : partial root, OUT_W bits; q_o shifts in the new root bit
module isqrt_step #(
   parameter int unsigned OUT_W = 24
) (
   input  logic [1:0]       a_top2_i,
   input  logic [OUT_W+1:0] r_i,
   input  logic [OUT_W-1:0] q_i,
   output logic [OUT_W+1:0] r_o,
   output logic [OUT_W-1:0] q_o
);

   logic [OUT_W+1:0] left;
   logic [OUT_W+1:0] right;

   // Dropping r's top two bits is a x4 modulo 2^(OUT_W+2); the sign survives
   // because |r| stays below 2^OUT_W.
   assign left  = {r_i[OUT_W-1:0], a_top2_i};
   assign right = {q_i, r_i[OUT_W+1], 1'b1};
   assign r_o   = r_i[OUT_W+1] ? (left + right) : (left - right);
   assign q_o   = {q_i[OUT_W-2:0], ~r_o[OUT_W+1]};

endmodule

// File: rtl/isqrt_iter.sv
// isqrt_iter -- multi-cycle floor(sqrt(in_data)), BITS_PER_CYC root bits per clock.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand handshake (ready only in IDLE)
//   in_data              : IN_W-bit unsigned radicand
//   out_valid/out_ready  : result handshake, result held until accepted
//   out_root             : OUT_W-bit root
//   out_rem              : OUT_W+1-bit remainder, only when ISQRT_REM_EN is defined
// Optional feature macro: ISQRT_REM_EN (remainder port plus final correction adder).
module isqrt_iter
   import isqrt_pkg::*;
#(
   parameter  int unsigned IN_W         = 48,
   parameter  int unsigned BITS_PER_CYC = 1,
   localparam int unsigned OUT_W        = IN_W / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef ISQRT_REM_EN
   output logic [OUT_W-1:0] out_root,
   output logic [OUT_W:0]   out_rem
`else
   output logic [OUT_W-1:0] out_root
`endif
);

   localparam int unsigned ITER  = isqrt_iter_count(IN_W, BITS_PER_CYC);
   localparam int unsigned CNT_W = $clog2(ITER + 1);

   if (!isqrt_cfg_ok(IN_W, BITS_PER_CYC)) begin : g_cfg_err
      $error("isqrt_iter: illegal IN_W / BITS_PER_CYC combination");
   end

   isqrt_state_e     state_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [OUT_W-1:0] out_root_q;
   logic [IN_W-1:0]  a_q, a_d;
   logic [OUT_W+1:0] r_q, r_d;
   logic [OUT_W-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q;

   // Step chain: BITS_PER_CYC non-restoring steps per clock.
   logic [IN_W-1:0]  a_ch [BITS_PER_CYC+1];
   logic [OUT_W+1:0] r_ch [BITS_PER_CYC+1];
   logic [OUT_W-1:0] q_ch [BITS_PER_CYC+1];

   assign a_ch[0] = a_q;
   assign r_ch[0] = r_q;
   assign q_ch[0] = q_q;

   for (genvar k = 0; k < BITS_PER_CYC; k++) begin : g_step
      isqrt_step #(.OUT_W(OUT_W)) u_step (
         .a_top2_i (a_ch[k][IN_W-1 -: 2]),
         .r_i      (r_ch[k]),
         .q_i      (q_ch[k]),
         .r_o      (r_ch[k+1]),
         .q_o      (q_ch[k+1])
      );
      assign a_ch[k+1] = a_ch[k] << 2;
   end

   assign a_d = a_ch[BITS_PER_CYC];
   assign r_d = r_ch[BITS_PER_CYC];
   assign q_d = q_ch[BITS_PER_CYC];

`ifdef ISQRT_REM_EN
   logic [OUT_W:0]   out_rem_q;
   logic [OUT_W+1:0] r_fix;

   // A negative final remainder is restored by adding back 2q+1.
   assign r_fix   = r_q[OUT_W+1] ? (r_q + {1'b0, q_q, 1'b1}) : r_q;
   assign out_rem = out_rem_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_root_q  <= '0;
         a_q         <= '0;
         r_q         <= '0;
         q_q         <= '0;
         cnt_q       <= '0;
`ifdef ISQRT_REM_EN
         out_rem_q   <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= in_data;
                  r_q        <= '0;
                  q_q        <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= CALC;
               end
            end
            CALC: begin
               // ITER step cycles, then one cycle to load the result registers.
               if (cnt_q == CNT_W'(ITER)) begin
                  out_root_q  <= q_q;
`ifdef ISQRT_REM_EN
                  out_rem_q   <= r_fix[OUT_W:0];
`endif
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  a_q   <= a_d;
                  r_q   <= r_d;
                  q_q   <= q_d;
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_root  = out_root_q;

endmodule

// File: tb/tb_isqrt_iter.sv
// tb_isqrt_iter -- directed checks of isqrt_iter with BITS_PER_CYC=1 (u1) and
// BITS_PER_CYC=4 (u4). Remainder checks apply when ISQRT_REM_EN is defined.
module tb_isqrt_iter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv  [2];
   logic        ir  [2];
   logic [47:0] id  [2];
   logic        ov  [2];
   logic        ordy[2];
   logic [23:0] root[2];
`ifdef ISQRT_REM_EN
   logic [24:0] rem [2];
`endif

   int unsigned nvec = 0;
   int unsigned nmis = 0;

   always #5 clk = ~clk;

   isqrt_iter #(.IN_W(48), .BITS_PER_CYC(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]),
`ifdef ISQRT_REM_EN
      .out_rem(rem[0]),
`endif
      .out_root(root[0])
   );

   isqrt_iter #(.IN_W(48), .BITS_PER_CYC(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]),
`ifdef ISQRT_REM_EN
      .out_rem(rem[1]),
`endif
      .out_root(root[1])
   );

   // Greedy bit-by-bit root by squaring, independent of the digit recurrence.
   function automatic logic [23:0] ref_root(input logic [47:0] x);
      logic [63:0] r = '0;
      logic [63:0] t;
      for (int b = 23; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t <= {16'd0, x}) r = t;
      end
      return r[23:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start(input int s, input logic [47:0] x);
      @(negedge clk);
      chk("in_ready_idle", 64'(ir[s]), 64'd1);
      iv[s] = 1'b1;
      id[s] = x;
      @(negedge clk);
      iv[s] = 1'b0;
   endtask

   // Returns the number of edges after the accepting edge until out_valid rises.
   task automatic wait_done(input int s, output int lat);
      lat = 0;
      while (ov[s] !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic ack(input int s);
      ordy[s] = 1'b1;
      @(negedge clk);
      ordy[s] = 1'b0;
      chk("out_valid_drop", 64'(ov[s]), 64'd0);
   endtask

   task automatic run(input int s, input logic [47:0] x, input logic [23:0] er,
                      input logic [24:0] erem, input int elat);
      int lat;
      start(s, x);
      wait_done(s, lat);
      chk("latency", 64'(lat), 64'(elat));
      chk("root", 64'(root[s]), 64'(er));
`ifdef ISQRT_REM_EN
      chk("rem", 64'(rem[s]), 64'(erem));
`endif
      ack(s);
   endtask

   initial begin
      int          lat;
      logic [63:0] rnd;
      logic [47:0] x;
      logic [23:0] e;

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0; id[i] = '0; ordy[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(ir[0]), 64'd1);
      chk("rst_out_valid", 64'(ov[0]), 64'd0);
      chk("rst_out_root", 64'(root[0]), 64'd0);
`ifdef ISQRT_REM_EN
      chk("rst_out_rem", 64'(rem[0]), 64'd0);
`endif
      rst_n = 1'b1;

      // Basic results, 24 step cycles + 1 load cycle.
      run(0, 48'd25, 24'd5, 25'd0, 25);
      run(0, 48'd33, 24'd5, 25'd8, 25);
      run(0, 48'd3300000000, 24'd57445, 25'd71975, 25);
      run(0, 48'd0, 24'd0, 25'd0, 25);
      run(0, 48'hFFFF_FFFF_FFFF, 24'd16777215, 25'd33554430, 25);
      run(0, 48'd281474943156225, 24'd16777215, 25'd0, 25);

      // Back-pressure: result held, no capture of a new operand while busy.
      start(0, 48'd33);
      wait_done(0, lat);
      chk("bp_latency", 64'(lat), 64'd25);
      for (int i = 0; i < 10; i++) begin
         iv[0] = 1'b1;
         id[0] = 48'd777;
         @(negedge clk);
         chk("bp_out_valid", 64'(ov[0]), 64'd1);
         chk("bp_out_root", 64'(root[0]), 64'd5);
         chk("bp_in_ready", 64'(ir[0]), 64'd0);
      end
      iv[0] = 1'b0;
      ack(0);
      repeat (3) @(negedge clk);
      chk("bp_no_capture_ready", 64'(ir[0]), 64'd1);
      chk("bp_no_capture_valid", 64'(ov[0]), 64'd0);

      // Reset in the middle of CALC: no result, back to idle.
      start(0, 48'd123456789);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_in_ready", 64'(ir[0]), 64'd1);
      chk("midrst_out_valid", 64'(ov[0]), 64'd0);
      chk("midrst_out_root", 64'(root[0]), 64'd0);
      repeat (30) begin
         @(negedge clk);
         chk("midrst_no_pulse", 64'(ov[0]), 64'd0);
      end
      run(0, 48'd96100, 24'd310, 25'd0, 25);

      // Four bits per cycle: 6 step cycles + 1 load cycle.
      run(1, 48'd4000000, 24'd2000, 25'd0, 7);
      run(1, 48'hFFFF_FFFF_FFFF, 24'd16777215, 25'd33554430, 7);
      run(1, 48'd0, 24'd0, 25'd0, 7);
      run(1, 48'd3300000000, 24'd57445, 25'd71975, 7);

      for (int i = 0; i < 1000; i++) begin
         rnd = {$urandom, $urandom};
         x   = rnd[47:0] >> (i % 48);
         e   = ref_root(x);
         run(1, x, e, 25'(x - 48'(e) * 48'(e)), 7);
      end
      for (int i = 0; i < 20; i++) begin
         rnd = {$urandom, $urandom};
         x   = rnd[47:0];
         e   = ref_root(x);
         run(0, x, e, 25'(x - 48'(e) * 48'(e)), 25);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
